// File: rtl/logic_op_identifier.sv
// logic_op_identifier: recovers the 2-bit logic-unit control code
// (00 AND, 01 OR, 10 NOR, 11 XOR) from observed (A, B, out) samples.
// Each sample removes the operations it contradicts. The session ends when
// at most one candidate is left or the sample limit is reached.
module logic_op_identifier #(
    parameter int W           = 32,
    parameter int MAX_SAMPLES = 16,
    parameter int CNT_W       = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     A,
    input  logic [W-1:0]     B,
    input  logic [W-1:0]     out,
    output logic             done,
    output logic             found,
    output logic [1:0]       control,
    output logic [3:0]       candidates,
    output logic [CNT_W-1:0] sample_count
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             found_q, found_d;
    logic [1:0]       ctrl_q, ctrl_d;

    logic [3:0]       match;
    logic [3:0]       mask_new;
    logic             accept;
    logic             last;

    function automatic logic [2:0] popcount4(input logic [3:0] m);
        return 3'(m[0]) + 3'(m[1]) + 3'(m[2]) + 3'(m[3]);
    endfunction

    // Only meaningful for one-hot masks; anything else decodes to 00.
    function automatic logic [1:0] onehot_index(input logic [3:0] m);
        logic [1:0] idx;
        case (m)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Per-operation consistency of the current sample and the accept decision.
    // start wins over a simultaneous sample, which is then dropped.
    always_comb begin
        match[0] = ((A & B) == out);
        match[1] = ((A | B) == out);
        match[2] = (~(A | B) == out);
        match[3] = ((A ^ B) == out);
        mask_new = cand_q & match;
        accept   = in_valid && (state_q == S_COLLECT) && !start;
        last     = (popcount4(mask_new) <= 3'd1) ||
                   ((cnt_q + 1'b1) == CNT_W'(MAX_SAMPLES));
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_COLLECT;
            end
            S_COLLECT: begin
                if (start)               state_d = S_COLLECT;
                else if (accept && last) state_d = S_DONE;
            end
            S_DONE: begin
                if (start) state_d = S_COLLECT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from state.
    always_comb begin
        in_ready = (state_q == S_COLLECT);
    end

    // Next values of the session registers.
    // The result fields are computed from the new mask, so they appear on the
    // same edge that accepts the decisive sample.
    always_comb begin
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        found_d = found_q;
        ctrl_d  = ctrl_q;
        if (start) begin
            cand_d  = 4'b1111;
            cnt_d   = '0;
            done_d  = 1'b0;
            found_d = 1'b0;
            ctrl_d  = 2'd0;
        end else if (accept) begin
            cand_d = mask_new;
            cnt_d  = cnt_q + 1'b1;
            if (last) begin
                done_d  = 1'b1;
                found_d = (popcount4(mask_new) == 3'd1);
                ctrl_d  = onehot_index(mask_new);
            end
        end
    end

    // Session registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cand_q  <= 4'b1111;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            found_q <= 1'b0;
            ctrl_q  <= 2'd0;
        end else begin
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            found_q <= found_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign candidates   = cand_q;
    assign sample_count = cnt_q;
    assign done         = done_q;
    assign found        = found_q;
    assign control      = ctrl_q;

endmodule

// File: tb/tb_logic_op_identifier.sv
// Directed bench for logic_op_identifier with hand-computed expectations.
module tb_logic_op_identifier;

    localparam int W     = 32;
    localparam int MAXS  = 16;
    localparam int CNT_W = 5;

    logic             clock;
    logic             reset_n;
    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     A;
    logic [W-1:0]     B;
    logic [W-1:0]     out;
    logic             done;
    logic             found;
    logic [1:0]       control;
    logic [3:0]       candidates;
    logic [CNT_W-1:0] sample_count;

    int nvec = 0;
    int nmis = 0;

    logic_op_identifier #(.W(W), .MAX_SAMPLES(MAXS), .CNT_W(CNT_W)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .A            (A),
        .B            (B),
        .out          (out),
        .done         (done),
        .found        (found),
        .control      (control),
        .candidates   (candidates),
        .sample_count (sample_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nmis++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start();
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] o);
        @(negedge clock);
        A = a; B = b; out = o; in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic d, input logic f,
                                input logic [1:0] c, input logic [3:0] m, input int n);
        check({tag, ".done"},  32'(done), 32'(d));
        check({tag, ".found"}, 32'(found), 32'(f));
        check({tag, ".ctrl"},  32'(control), 32'(c));
        check({tag, ".cand"},  32'(candidates), 32'(m));
        check({tag, ".count"}, 32'(sample_count), 32'(n));
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; in_valid = 1'b0;
        A = '0; B = '0; out = '0;
        repeat (3) @(posedge clock);
        #1;
        check_result("rst", 1'b0, 1'b0, 2'd0, 4'b1111, 0);
        check("rst.ready", 32'(in_ready), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // IDLE ignores samples
        send(32'h0, 32'h0, 32'h1);
        check_result("idle", 1'b0, 1'b0, 2'd0, 4'b1111, 0);
        check("idle.ready", 32'(in_ready), 32'd0);

        // 1: single-sample AND identification
        do_start();
        check("t1.ready", 32'(in_ready), 32'd1);
        send(32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000);
        check_result("t1", 1'b1, 1'b1, 2'd0, 4'b0001, 1);
        check("t1.ready", 32'(in_ready), 32'd0);

        // 2: progressive elimination down to XOR (start from DONE)
        do_start();
        check_result("t2.clr", 1'b0, 1'b0, 2'd0, 4'b1111, 0);
        send(32'h0, 32'h0, 32'h0);
        check_result("t2.s1", 1'b0, 1'b0, 2'd0, 4'b1011, 1);
        @(posedge clock); #1;
        check_result("t2.gap", 1'b0, 1'b0, 2'd0, 4'b1011, 1);
        send(32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF);
        check_result("t2.s2", 1'b0, 1'b0, 2'd0, 4'b1010, 2);
        send(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0);
        check_result("t2.s3", 1'b1, 1'b1, 2'd3, 4'b1000, 3);

        // 3: inconsistent sample empties the mask
        do_start();
        send(32'h0, 32'h0, 32'h1);
        check_result("t3", 1'b1, 1'b0, 2'd0, 4'b0000, 1);

        // 4: ambiguous until the sample limit, with valid gaps
        do_start();
        for (int i = 0; i < MAXS; i++) begin
            send(32'h0, 32'h0, 32'h0);
            if (i < MAXS - 1) begin
                check("t4.early_done", 32'(done), 32'd0);
                @(posedge clock); #1;
            end
        end
        check_result("t4", 1'b1, 1'b0, 2'd0, 4'b1011, MAXS);
        // samples in DONE are not taken
        send(32'h0, 32'h0, 32'h1);
        check_result("t4.hold", 1'b1, 1'b0, 2'd0, 4'b1011, MAXS);

        // 5: start beats a simultaneous sample
        do_start();
        send(32'h0, 32'h0, 32'h0);
        send(32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF);
        check_result("t5.pre", 1'b0, 1'b0, 2'd0, 4'b1010, 2);
        @(negedge clock);
        start = 1'b1; in_valid = 1'b1;
        A = 32'hFFFFFFFF; B = 32'hFFFFFFFF; out = 32'h0;
        @(posedge clock); #1;
        start = 1'b0; in_valid = 1'b0;
        check_result("t5", 1'b0, 1'b0, 2'd0, 4'b1111, 0);
        check("t5.ready", 32'(in_ready), 32'd1);

        // 6: asynchronous reset between edges
        send(32'h0, 32'h0, 32'h0);
        check_result("t6.pre", 1'b0, 1'b0, 2'd0, 4'b1011, 1);
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check_result("t6.rst", 1'b0, 1'b0, 2'd0, 4'b1111, 0);
        check("t6.rst.ready", 32'(in_ready), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("t6.post.ready", 32'(in_ready), 32'd0);
        do_start();
        check("t6.start.ready", 32'(in_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/logic_op_identifier.md
Name: logic_op_identifier

Overview:
- Inverse of the 2-bit logic-unit encoding: 00 AND, 01 OR, 10 NOR, 11 XOR.
- Watches a stream of (A, B, out) samples and eliminates every operation inconsistent with them.
- Reports which control code produced the results, or reports that none or several fit.
- Used as a self-check/trace decoder beside the ALU datapath.

Parameters:
W, 32, data width of A, B, out.
MAX_SAMPLES, 16, maximum samples per session before forced completion.
CNT_W, 5, count width; must be at least ceil(log2(MAX_SAMPLES+1)).

Ports:
clock  input  1  single clock; all state updates on rising edge.
reset_n  input  1  asynchronous, active-low reset.
start  input  1  begins or restarts a session.
in_valid  input  1  sample present on A/B/out.
in_ready  output  1  block accepts a sample this cycle.
A  input  W  operand A of observed operation.
B  input  W  operand B of observed operation.
out  input  W  observed result.
done  output  1  session finished; result fields valid.
found  output  1  exactly one operation consistent (valid when done=1).
control  output  2  identified control code (valid when found=1).
candidates  output  4  live mask; bit i set means control code i is still consistent.
sample_count  output  CNT_W  samples accepted this session.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, candidates=4'b1111, control=00, done=0, found=0, sample_count=0, in_ready=0.
- Outputs are registered; in_ready is decoded from state (1 only in COLLECT).
- States: IDLE, COLLECT, DONE.
- IDLE:
  - in_ready=0; in_valid is ignored.
  - start=1 -> COLLECT next cycle; candidates=1111, count=0, done=0, found=0, control=00.
- COLLECT:
  - in_ready=1. A sample is accepted when in_valid & in_ready & !start.
  - match[0]=((A&B)==out), match[1]=((A|B)==out), match[2]=(~(A|B)==out), match[3]=((A^B)==out). All are full W-bit compares.
  - On accept: candidates <= candidates & match; sample_count <= sample_count+1.
  - Go to DONE on the same edge if popcount(new mask)<=1 or sample_count+1==MAX_SAMPLES.
- DONE:
  - in_ready=0, done=1; candidates and sample_count hold.
  - found=1 iff popcount(candidates)==1; control=index of the set bit when found, else 00.
  - Holds indefinitely; start=1 -> COLLECT with cleared state, as from IDLE.
- Latency: the decisive sample accepted at edge N gives done/found/control visible after edge N (one cycle after the accept cycle).
- start has priority over a sample in the same cycle; that sample is dropped and not counted.
- start in COLLECT restarts the session: mask=1111, count=0.
- in_valid gaps in COLLECT do not change state.
- Empty mask (0000): DONE with found=0.
- Ambiguous at MAX_SAMPLES (>=2 bits set): DONE with found=0; candidates shows the survivors.
- reset_n asserted mid-session: immediate return to reset values with no clock edge; the session is lost.
- The count never exceeds MAX_SAMPLES and never wraps.

Test Plan:
1. Single-sample identification:
   - Stimulus: start; then one sample A=0xF0F0F0F0, B=0xFF00FF00, out=0xF000F000.
   - Response: next cycle done=1, found=1, control=00, candidates=0001, sample_count=1, in_ready=0.
2. Progressive elimination:
   - Stimulus: samples (0,0,0), then (0xFFFFFFFF,0,0xFFFFFFFF), then (0xFFFFFFFF,0xFFFFFFFF,0).
   - Response: candidates 1011 -> 1010 -> 1000; done after the third accept; control=11, count=3.
3. Inconsistent sample:
   - Stimulus: A=0, B=0, out=0x00000001.
   - Response: candidates=0000, done=1, found=0, control=00, count=1.
4. Ambiguous to limit:
   - Stimulus: 16 samples of (0,0,0) with in_valid toggled 1/0 between samples.
   - Response: done asserts only after the 16th accept; candidates=1011, found=0, count=16; no done before.
5. Restart priority:
   - Stimulus: in COLLECT after 2 samples (mask 1010), assert start with in_valid=1 and a sample that would eliminate.
   - Response: mask=1111, count=0, done=0; the sample is not applied.
6. Async reset:
   - Stimulus: drop reset_n mid-COLLECT between clock edges.
   - Response: outputs go to reset values immediately; after release, in_ready=0 until start.
